// File: rtl/vm_pkg.sv
// vm_pkg: shared states, coin values and widths for the payment initiator
package vm_pkg;
    localparam int PRICE_W = 5;
    localparam int ITEM_W  = 4;
    localparam int CNT_W   = 4;
    localparam int TMR_W   = 8;
    localparam logic [PRICE_W-1:0] FIVE = 5'd1;
    localparam logic [PRICE_W-1:0] TEN  = 5'd2;
    typedef enum logic [2:0] {IDLE, PAY, WAIT, CHANGE, DONE, ERR} state_t;
    // Units paid by the next coin: a ten-coin never pays more than what is left
    function automatic logic [PRICE_W-1:0] coin_units(input logic ten, input logic [PRICE_W-1:0] rem);
        return ten ? (rem < TEN ? rem : TEN) : FIVE;
    endfunction
endpackage

// File: rtl/vm_payment_initiator_if.sv
// vm_payment_initiator_if: host/machine signals of the payment initiator
interface vm_payment_initiator_if;
    import vm_pkg::*;
    logic               start;
    logic [ITEM_W-1:0]  item_sel;
    logic [PRICE_W-1:0] price_units;
    logic               use_ten;
    logic               dispense;
    logic               five_out;
    logic [ITEM_W-1:0]  item;
    logic               five_in;
    logic               ten_in;
    logic               busy;
    logic               done;
    logic               error;
    logic [CNT_W-1:0]   change_cnt;
    modport master (output start, item_sel, price_units, use_ten, dispense, five_out,
                    input  item, five_in, ten_in, busy, done, error, change_cnt);
    modport slave  (input  start, item_sel, price_units, use_ten, dispense, five_out,
                    output item, five_in, ten_in, busy, done, error, change_cnt);
endinterface

// File: rtl/vm_cycle_timer.sv
// vm_cycle_timer: loadable down-counter, expired while the count sits at zero
module vm_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // Load wins, otherwise count down and park at zero
    always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // Count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/vm_payment_initiator.sv
// vm_payment_initiator: pays for a vending item coin by coin and tracks change
// Define VM_PAYINIT_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT cycles.
module vm_payment_initiator import vm_pkg::*; #(
    parameter int TIMEOUT    = 8,
    parameter int CHANGE_WIN = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    vm_payment_initiator_if.slave  bus
);
    state_t             state_q;
    logic [PRICE_W-1:0] rem_q;
    logic [ITEM_W-1:0]  item_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               use_ten_q, disp_seen_q, five_q, ten_q, busy_q, done_q, error_q;
    logic               pay_end, go_change, tmr_load, tmr_exp, cnt_inc;
    logic [TMR_W-1:0]   tmr_val;
    logic [PRICE_W-1:0] coin;
    assign pay_end   = state_q == PAY && rem_q == '0;
    assign go_change = disp_seen_q | bus.dispense;
    assign coin      = coin_units(use_ten_q, rem_q);
    assign cnt_inc   = bus.five_out && cnt_q != '1 && (state_q == PAY || state_q == WAIT || state_q == CHANGE);
`ifdef VM_PAYINIT_TIMEOUT_EN
    assign tmr_load  = pay_end || (state_q == WAIT && bus.dispense);
`else
    assign tmr_load  = (pay_end && go_change) || (state_q == WAIT && bus.dispense);
`endif
    assign tmr_val   = go_change ? TMR_W'(CHANGE_WIN - 1) : TMR_W'(TIMEOUT - 1);
    vm_cycle_timer #(.W(TMR_W)) u_timer (
        .clk(clk), .rst_n(rst_n), .load_i(tmr_load), .val_i(tmr_val), .expired_o(tmr_exp)
    );
    // Transaction FSM with registered coin, status and change outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            item_q      <= '0;
            cnt_q       <= '0;
            use_ten_q   <= 1'b0;
            disp_seen_q <= 1'b0;
            five_q      <= 1'b0;
            ten_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            five_q  <= 1'b0;
            ten_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: if (bus.start) begin
                    busy_q <= 1'b1;
                    if (bus.price_units == '0) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end else begin
                        state_q     <= PAY;
                        item_q      <= bus.item_sel;
                        use_ten_q   <= bus.use_ten;
                        disp_seen_q <= 1'b0;
                        cnt_q       <= '0;
                        five_q      <= !bus.use_ten;
                        ten_q       <= bus.use_ten;
                        rem_q       <= bus.price_units - coin_units(bus.use_ten, bus.price_units);
                    end
                end
                PAY: begin
                    if (bus.dispense) disp_seen_q <= 1'b1;
                    if (rem_q == '0) state_q <= go_change ? CHANGE : WAIT;
                    else begin
                        five_q <= !use_ten_q;
                        ten_q  <= use_ten_q;
                        rem_q  <= rem_q - coin;
                    end
                end
                WAIT: begin
                    if (bus.dispense) state_q <= CHANGE;
`ifdef VM_PAYINIT_TIMEOUT_EN
                    else if (tmr_exp) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end
`endif
                end
                CHANGE: if (tmr_exp) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.item       = item_q;
    assign bus.five_in    = five_q;
    assign bus.ten_in     = ten_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.change_cnt = cnt_q;
endmodule

// File: tb/tb_vm_payment_initiator.sv
// tb_vm_payment_initiator: directed checks of the payment initiator
module tb_vm_payment_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vm_payment_initiator_if bus();
    vm_payment_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [3:0] it, input logic [4:0] pr, input logic ten);
        bus.item_sel = it;
        bus.price_units = pr;
        bus.use_ten = ten;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 0; bus.item_sel = 0; bus.price_units = 0; bus.use_ten = 0;
        bus.dispense = 0; bus.five_out = 0;
        tick; tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_item", bus.item, 0);
        chk("rst_coins", {bus.five_in, bus.ten_in}, 0);
        chk("rst_flags", {bus.done, bus.error}, 0);
        chk("rst_cnt", bus.change_cnt, 0);
        rst_n = 1'b1;
        tick;
        // three five-coins, dispense in WAIT
        go(4'h5, 5'd3, 1'b0);
        chk("a_item", bus.item, 5);
        chk("a_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            chk("a_five", bus.five_in, 1);
            chk("a_ten", bus.ten_in, 0);
            tick;
        end
        chk("a_wait_coins", {bus.five_in, bus.ten_in}, 0);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        chk("a_chg1_done", bus.done, 0);
        tick;
        chk("a_chg2_done", bus.done, 0);
        tick;
        chk("a_done", bus.done, 1);
        chk("a_cnt", bus.change_cnt, 0);
        tick;
        chk("a_idle_busy", bus.busy, 0);
        chk("a_idle_done", bus.done, 0);
        // two ten-coins with one five-coin of change
        go(4'h9, 5'd3, 1'b1);
        chk("b_ten1", {bus.five_in, bus.ten_in}, 2'b01);
        tick;
        chk("b_ten2", {bus.five_in, bus.ten_in}, 2'b01);
        bus.five_out = 1'b1;
        tick;
        bus.five_out = 1'b0;
        chk("b_wait_coins", {bus.five_in, bus.ten_in}, 0);
        chk("b_cnt_pay", bus.change_cnt, 1);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        tick; tick;
        chk("b_done", bus.done, 1);
        chk("b_cnt", bus.change_cnt, 1);
        tick;
        chk("b_idle_busy", bus.busy, 0);
        chk("b_cnt_hold", bus.change_cnt, 1);
        // illegal price
        go(4'h2, 5'd0, 1'b0);
        chk("c_error", bus.error, 1);
        chk("c_busy", bus.busy, 1);
        chk("c_coins", {bus.five_in, bus.ten_in}, 0);
        tick;
        chk("c_error_clr", bus.error, 0);
        chk("c_busy_clr", bus.busy, 0);
        // dispense during PAY skips WAIT
        go(4'h4, 5'd2, 1'b0);
        chk("d_five1", bus.five_in, 1);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        chk("d_five2", bus.five_in, 1);
        tick;
        chk("d_chg_coins", {bus.five_in, bus.ten_in}, 0);
        tick;
        chk("d_chg_done", bus.done, 0);
        tick;
        chk("d_done", bus.done, 1);
        tick;
        chk("d_done_clr", bus.done, 0);
        // asynchronous reset during the second coin
        go(4'h3, 5'd4, 1'b0);
        tick;
        chk("e_five2", bus.five_in, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_five", bus.five_in, 0);
        chk("e_rst_busy", bus.busy, 0);
        chk("e_rst_item", bus.item, 0);
        tick; tick;
        chk("e_rst_flags", {bus.done, bus.error}, 0);
        rst_n = 1'b1;
        tick;
        chk("e_post_flags", {bus.done, bus.error, bus.busy}, 0);
        go(4'h7, 5'd1, 1'b1);
        chk("e_new_ten", {bus.five_in, bus.ten_in}, 2'b01);
        chk("e_new_item", bus.item, 7);
        tick;
        chk("e_new_wait", {bus.five_in, bus.ten_in}, 0);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        tick; tick;
        chk("e_new_done", bus.done, 1);
        tick;
        // saturating change count, start while busy ignored
        go(4'hA, 5'd15, 1'b0);
        bus.five_out = 1'b1;
        bus.item_sel = 4'hF;
        bus.price_units = 5'd9;
        bus.use_ten = 1'b1;
        bus.start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 1) chk("f_coin_keep", {bus.five_in, bus.ten_in}, 2'b10);
            if (i == 5) chk("f_cnt5", bus.change_cnt, 5);
        end
        bus.five_out = 1'b0;
        bus.start = 1'b0;
        chk("f_cnt_sat", bus.change_cnt, 15);
        chk("f_item_keep", bus.item, 4'hA);
        chk("f_busy", bus.busy, 1);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        tick; tick;
        chk("f_done", bus.done, 1);
        chk("f_cnt_done", bus.change_cnt, 15);
        tick;
        // dispense never arrives
        go(4'h1, 5'd1, 1'b0);
        chk("g_five", bus.five_in, 1);
        tick;
        for (int i = 0; i < 8; i++) begin
            chk("g_wait_err", bus.error, 0);
            tick;
        end
`ifdef VM_PAYINIT_TIMEOUT_EN
        chk("g_timeout_err", bus.error, 1);
        chk("g_timeout_done", bus.done, 0);
        tick;
        chk("g_idle_busy", bus.busy, 0);
        chk("g_err_clr", bus.error, 0);
`else
        for (int i = 0; i < 10; i++) tick;
        chk("g_hold_busy", bus.busy, 1);
        chk("g_hold_err", bus.error, 0);
        bus.dispense = 1'b1;
        tick;
        bus.dispense = 1'b0;
        tick; tick;
        chk("g_done", bus.done, 1);
        tick;
        chk("g_idle_busy", bus.busy, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vm_payment_initiator.md
VM_PAYMENT_INITIATOR -- requirements
Module: vm_payment_initiator

Interface
REQ-001 Parameter TIMEOUT, default 8, cycles allowed in WAIT for dispense before error.
REQ-002 Parameter CHANGE_WIN, default 2, cycles after dispense during which five_out is still counted.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 resets immediately).
REQ-005 start  input  1  one-cycle request to purchase; ignored unless busy==0.
REQ-006 item_sel  input  4  item code captured on accepted start.
REQ-007 price_units  input  5  price in 5-unit steps, captured on accepted start; 0 is illegal.
REQ-008 use_ten  input  1  prefer ten-coins, captured on accepted start.
REQ-009 item  output  4  registered item code presented to machine.
REQ-010 five_in  output  1  one-cycle five-coin pulse to machine.
REQ-011 ten_in  output  1  one-cycle ten-coin pulse to machine.
REQ-012 dispense  input  1  machine dispense indication.
REQ-013 five_out  input  1  machine change pulse, one per five-coin returned.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 error  output  1  one-cycle pulse on timeout or illegal price.
REQ-017 change_cnt  output  4  five-coins returned in last transaction, saturating at 15.

Function
REQ-018 States SHALL be IDLE, PAY, WAIT, CHANGE, DONE, ERR.
REQ-019 IDLE->PAY on start with price_units!=0; IDLE->ERR on start with price_units==0; otherwise stay.
REQ-020 Accepted start SHALL clear change_cnt, load remaining=price_units, latch item/use_ten; item updates same edge.
REQ-021 PAY: one coin per cycle; five_in and ten_in SHALL never be high together.
REQ-022 PAY coin choice: use_ten==1 -> ten_in, remaining -= min(2,remaining); use_ten==0 -> five_in, remaining -= 1.
REQ-023 PAY->WAIT on the cycle remaining reaches 0; first coin appears the cycle after start (latency 1).
REQ-024 WAIT: no coin outputs; dispense==1 -> CHANGE; timeout counter counts WAIT cycles.
REQ-025 CHANGE: lasts exactly CHANGE_WIN cycles, then DONE.
REQ-026 five_out SHALL increment change_cnt in PAY, WAIT and CHANGE only; saturate at 15, never wrap.
REQ-027 dispense seen during PAY SHALL be recorded and cause PAY->CHANGE when payment completes, skipping WAIT.
REQ-028 DONE: done=1 for one cycle, then IDLE; ERR: error=1 for one cycle, then IDLE.
REQ-029 start while busy SHALL be ignored with no effect on latched operands.
REQ-030 change_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-031 reset==0 SHALL asynchronously force IDLE, five_in=0, ten_in=0, item=0, busy=0, done=0, error=0, change_cnt=0, counters cleared.
REQ-032 Reset mid-transaction SHALL abandon it without done or error pulse; release resumes in IDLE.

Configuration
REQ-033 Macro VM_PAYINIT_TIMEOUT_EN defined: WAIT exceeding TIMEOUT cycles without dispense -> ERR.
REQ-034 Macro undefined: no timeout counter, WAIT holds indefinitely, only illegal price drives error.

Structure
REQ-035 Shared package vm_pkg SHALL hold state enum, coin value constants (FIVE=1, TEN=2 units) and width constants.
REQ-036 One sub-module vm_cycle_timer (loadable down-counter with expiry flag) SHALL serve WAIT timeout and CHANGE window.

Verification
REQ-037 price_units=3, use_ten=0 -> three consecutive five_in pulses, no ten_in; dispense in WAIT -> done after CHANGE_WIN+1 cycles, change_cnt=0.
REQ-038 price_units=3, use_ten=1 -> ten_in, ten_in (overpay 1), machine returns one five_out -> done, change_cnt=1.
REQ-039 VM_PAYINIT_TIMEOUT_EN, price_units=1, dispense never -> five_in once, error pulse after TIMEOUT WAIT cycles, done never.
REQ-040 start with price_units=0 -> error pulse next cycle, no coins, busy high exactly one cycle.
REQ-041 reset low during second coin of price_units=4 -> outputs zero immediately, no done/error; new start afterward completes normally.
REQ-042 20 five_out pulses in one transaction -> change_cnt=15; start asserted while busy -> ignored.
